// File: rtl/pipe_decoder_pkg.sv
// Shared types, encodings and decode helpers for the pipe_decoder D->E stage.
// Widths are fixed here; the top and sequencer take them from this package.
package pipe_decoder_pkg;

    localparam int NREG     = 16;
    localparam int RIDX_W   = $clog2(NREG);
    localparam int ALUCTL_W = 4;
    localparam int OFF_W    = 6;

    typedef enum logic {IDLE, SEQ} seq_state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'b0100;

    // One bit per DP command: SUB RSB ADD ADC SBC RSC CMP CMN update C/V.
    localparam logic [15:0] ARITH_OPS = 16'h0CFC;

    typedef struct packed {
        logic                valid;
        logic [3:0]          cond;
        logic                pcs;
        logic                reg_w;
        logic                mem_w;
        logic                mem_to_reg;
        logic                branch;
        logic                alu_src;
        logic                byte_en;
        logic                bl;
        logic [ALUCTL_W-1:0] alu_ctl;
        logic [1:0]          flag_w;
        logic [RIDX_W-1:0]   rn;
        logic [RIDX_W-1:0]   rd;
        logic [OFF_W-1:0]    uop_off;
        logic                undef;
    } ctrl_e_t;

    // Valid bundle with no enables: the starting point for every non-DP decode.
    function automatic ctrl_e_t base_bundle(input logic [31:0] instr);
        ctrl_e_t c;
        c         = '0;
        c.valid   = 1'b1;
        c.cond    = instr[31:28];
        c.rn      = instr[19:16];
        c.rd      = instr[15:12];
        c.alu_ctl = ALU_ADD;
        return c;
    endfunction

    function automatic ctrl_e_t decode_single(input logic [31:0] instr);
        ctrl_e_t c;
        c = base_bundle(instr);
        case (instr[27:26])
            OP_DP: begin
                c.reg_w   = 1'b1;
                c.alu_src = instr[25];
                c.alu_ctl = instr[24:21];
                c.flag_w  = {instr[20], instr[20] & ARITH_OPS[instr[24:21]]};
            end
            OP_MEM: begin
                c.alu_src    = 1'b1;
                c.byte_en    = instr[22];
                c.reg_w      = instr[20];
                c.mem_to_reg = instr[20];
                c.mem_w      = ~instr[20];
            end
            OP_BR: begin
                c.branch  = 1'b1;
                c.alu_src = 1'b1;
                c.bl      = instr[24];
            end
            default: c.undef = 1'b1;
        endcase
        c.pcs = (c.rd == RIDX_W'(NREG - 1) && c.reg_w) || c.branch;
        return c;
    endfunction

    function automatic ctrl_e_t make_uop(input logic [3:0] cond, input logic [RIDX_W-1:0] rn,
                                         input logic [RIDX_W-1:0] rd, input logic [OFF_W-1:0] off,
                                         input logic load);
        ctrl_e_t c;
        c            = '0;
        c.valid      = 1'b1;
        c.cond       = cond;
        c.alu_src    = 1'b1;
        c.alu_ctl    = ALU_ADD;
        c.rn         = rn;
        c.rd         = rd;
        c.uop_off    = off;
        c.reg_w      = load;
        c.mem_to_reg = load;
        c.mem_w      = ~load;
        c.pcs        = load && (rd == RIDX_W'(NREG - 1));
        return c;
    endfunction

    function automatic ctrl_e_t make_wb(input logic [3:0] cond, input logic [RIDX_W-1:0] rn,
                                        input logic [OFF_W-1:0] off);
        ctrl_e_t c;
        c         = '0;
        c.valid   = 1'b1;
        c.cond    = cond;
        c.alu_src = 1'b1;
        c.alu_ctl = ALU_ADD;
        c.rn      = rn;
        c.rd      = rn;
        c.uop_off = off;
        c.reg_w   = 1'b1;
        c.pcs     = (rn == RIDX_W'(NREG - 1));
        return c;
    endfunction

endpackage

// File: rtl/reglist_prienc.sv
// Lowest-set-bit priority encoder over a register list, used to walk LDM/STM
// lists from r0 upward.
module reglist_prienc #(
    parameter int NREG = 16,
    parameter int IW   = $clog2(NREG)
) (
    input  logic [NREG-1:0] list,
    output logic [IW-1:0]   idx,
    output logic [NREG-1:0] onehot,
    output logic            more
);

    // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list[i]) idx = IW'(i);
        end
    end

    assign onehot = list & (~list + NREG'(1));
    assign more   = |(list & ~onehot);

endmodule

// File: rtl/pipe_decoder.sv
// Registered D->E decode stage with an LDM/STM (IA) micro-op sequencer.
// Optional feature macro: PIPE_DECODER_WB_UOP_EN adds a base-writeback micro-op for W=1.
module pipe_decoder
    import pipe_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         InstrD,
    input  logic                InstrValidD,
    input  logic                StallD,
    input  logic                FlushE,
    output logic                ReadyD,
    output logic                ValidE,
    output logic [3:0]          CondE,
    output logic                PCSE,
    output logic                RegWE,
    output logic                MemWE,
    output logic                MemtoRegE,
    output logic                BranchE,
    output logic                ALUSrcE,
    output logic                ByteEnE,
    output logic                BLE,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic [1:0]          FlagWE,
    output logic [RIDX_W-1:0]   RnE,
    output logic [RIDX_W-1:0]   RdE,
    output logic [OFF_W-1:0]    UopOffsetE,
    output logic                UndefE
);

    seq_state_t        state;
    ctrl_e_t           e_q;
    logic [NREG-1:0]   pend;
    logic [OFF_W-1:0]  off;
    logic [RIDX_W-1:0] rn_q;
    logic [3:0]        cond_q;
    logic              load_q;
    logic              wb_q;

    logic [NREG-1:0]   list_src;
    logic [NREG-1:0]   onehot;
    logic [RIDX_W-1:0] idx;
    logic              more;
    logic              is_block;
    logic              blk_ok;
    logic              wb_need;

    assign is_block = (InstrD[27:26] == OP_BR) && !InstrD[25];
    assign blk_ok   = !InstrD[24] && InstrD[23];
    assign list_src = (state == SEQ) ? pend : InstrD[NREG-1:0];

`ifdef PIPE_DECODER_WB_UOP_EN
    // A loaded base register wins over the writeback, so skip it in that case.
    assign wb_need = InstrD[21] && !(InstrD[20] && InstrD[InstrD[19:16]]);
`else
    assign wb_need = 1'b0;
`endif

    reglist_prienc #(.NREG(NREG), .IW(RIDX_W)) u_prienc (
        .list   (list_src),
        .idx    (idx),
        .onehot (onehot),
        .more   (more)
    );

    // NOTE: all state here is sequential and uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            e_q    <= '0;
            pend   <= '0;
            off    <= '0;
            rn_q   <= '0;
            cond_q <= '0;
            load_q <= 1'b0;
            wb_q   <= 1'b0;
        end else if (FlushE) begin
            state <= IDLE;
            e_q   <= '0;
            pend  <= '0;
            wb_q  <= 1'b0;
        end else if (!StallD) begin
            if (state == IDLE) begin
                if (!InstrValidD) begin
                    e_q <= '0;
                end else if (!is_block) begin
                    e_q <= decode_single(InstrD);
                end else if (!blk_ok) begin
                    e_q       <= base_bundle(InstrD);
                    e_q.undef <= 1'b1;
                end else if (InstrD[NREG-1:0] == '0) begin
                    e_q <= base_bundle(InstrD);
                end else begin
                    e_q    <= make_uop(InstrD[31:28], InstrD[19:16], idx, '0, InstrD[20]);
                    pend   <= InstrD[NREG-1:0] & ~onehot;
                    off    <= OFF_W'(4);
                    rn_q   <= InstrD[19:16];
                    cond_q <= InstrD[31:28];
                    load_q <= InstrD[20];
                    wb_q   <= wb_need;
                    if (more || wb_need) state <= SEQ;
                end
            end else if (pend != '0) begin
                e_q  <= make_uop(cond_q, rn_q, idx, off, load_q);
                pend <= pend & ~onehot;
                off  <= off + OFF_W'(4);
                if (!more && !wb_q) state <= IDLE;
            end else begin
                e_q   <= make_wb(cond_q, rn_q, off);
                wb_q  <= 1'b0;
                state <= IDLE;
            end
        end
    end

    assign ReadyD      = (state == IDLE);
    assign ValidE      = e_q.valid;
    assign CondE       = e_q.cond;
    assign PCSE        = e_q.pcs;
    assign RegWE       = e_q.reg_w;
    assign MemWE       = e_q.mem_w;
    assign MemtoRegE   = e_q.mem_to_reg;
    assign BranchE     = e_q.branch;
    assign ALUSrcE     = e_q.alu_src;
    assign ByteEnE     = e_q.byte_en;
    assign BLE         = e_q.bl;
    assign ALUControlE = e_q.alu_ctl;
    assign FlagWE      = e_q.flag_w;
    assign RnE         = e_q.rn;
    assign RdE         = e_q.rd;
    assign UopOffsetE  = e_q.uop_off;
    assign UndefE      = e_q.undef;

endmodule

// File: tb/tb_pipe_decoder.sv
// Self-checking bench for pipe_decoder: vector table, hand-written block-transfer
// sequences, and a randomized run against a queue-based reference model.
module tb_pipe_decoder;

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic       byte_en;
        logic       bl;
        logic [3:0] alu_ctl;
        logic [1:0] flag_w;
        logic [3:0] rn;
        logic [3:0] rd;
        logic [5:0] off;
        logic       undef;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic        InstrValidD, StallD, FlushE;
    logic        ReadyD, ValidE, PCSE, RegWE, MemWE, MemtoRegE, BranchE, ALUSrcE, ByteEnE, BLE, UndefE;
    logic [3:0]  CondE, ALUControlE, RnE, RdE;
    logic [1:0]  FlagWE;
    logic [5:0]  UopOffsetE;

    int   checks   = 0;
    int   failures = 0;
    out_t q[$];
    out_t cur;
    vec_t vecs[$];

    pipe_decoder dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .InstrValidD(InstrValidD),
        .StallD(StallD), .FlushE(FlushE), .ReadyD(ReadyD), .ValidE(ValidE), .CondE(CondE),
        .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE), .MemtoRegE(MemtoRegE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ByteEnE(ByteEnE), .BLE(BLE), .ALUControlE(ALUControlE),
        .FlagWE(FlagWE), .RnE(RnE), .RdE(RdE), .UopOffsetE(UopOffsetE), .UndefE(UndefE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        return {ValidE, CondE, PCSE, RegWE, MemWE, MemtoRegE, BranchE, ALUSrcE, ByteEnE, BLE,
                ALUControlE, FlagWE, RnE, RdE, UopOffsetE, UndefE};
    endfunction

    function automatic out_t base(input logic [3:0] cond, input logic [3:0] rn,
                                  input logic [3:0] rd, input logic [3:0] alu);
        out_t b;
        b         = '0;
        b.valid   = 1'b1;
        b.cond    = cond;
        b.rn      = rn;
        b.rd      = rd;
        b.alu_ctl = alu;
        return b;
    endfunction

    function automatic out_t uop_exp(input logic [3:0] cond, input logic [3:0] rn,
                                     input logic [3:0] rd, input logic [5:0] off, input logic load);
        out_t b;
        b            = base(cond, rn, rd, 4'b0100);
        b.alu_src    = 1'b1;
        b.off        = off;
        b.reg_w      = load;
        b.mem_to_reg = load;
        b.mem_w      = !load;
        b.pcs        = load && (rd == 4'd15);
        return b;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        InstrD      = ins;
        InstrValidD = v;
        StallD      = st;
        FlushE      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: an accepted instruction becomes the full list of E bundles it produces.
    task automatic model_expand(input logic [31:0] ins);
        out_t b;
        int   n;
        b = base(ins[31:28], ins[19:16], ins[15:12], 4'b0100);
        case (ins[27:26])
            2'b00: begin
                b.alu_ctl   = ins[24:21];
                b.reg_w     = 1'b1;
                b.alu_src   = ins[25];
                b.flag_w[1] = ins[20];
                b.flag_w[0] = ins[20] && (ins[24:21] inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11});
                b.pcs       = (ins[15:12] == 4'd15);
                q.push_back(b);
            end
            2'b01: begin
                b.alu_src = 1'b1;
                b.byte_en = ins[22];
                if (ins[20]) begin
                    b.reg_w      = 1'b1;
                    b.mem_to_reg = 1'b1;
                    b.pcs        = (ins[15:12] == 4'd15);
                end else begin
                    b.mem_w = 1'b1;
                end
                q.push_back(b);
            end
            2'b10: begin
                if (ins[25]) begin
                    b.branch  = 1'b1;
                    b.alu_src = 1'b1;
                    b.bl      = ins[24];
                    b.pcs     = 1'b1;
                    q.push_back(b);
                end else if (ins[24] || !ins[23]) begin
                    b.undef = 1'b1;
                    q.push_back(b);
                end else if (ins[15:0] == 16'h0) begin
                    q.push_back(b);
                end else begin
                    n = 0;
                    for (int i = 0; i < 16; i++) begin
                        if (ins[i]) begin
                            q.push_back(uop_exp(ins[31:28], ins[19:16], 4'(i), 6'(4 * n), ins[20]));
                            n++;
                        end
                    end
`ifdef PIPE_DECODER_WB_UOP_EN
                    if (ins[21] && !(ins[20] && ins[ins[19:16]])) begin
                        b = uop_exp(ins[31:28], ins[19:16], ins[19:16], 6'(4 * n), 1'b1);
                        b.mem_to_reg = 1'b0;
                        b.pcs        = (ins[19:16] == 4'd15);
                        q.push_back(b);
                    end
`endif
                end
            end
            default: begin
                b.undef = 1'b1;
                q.push_back(b);
            end
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          k;
        ins = $urandom;
        k   = $urandom_range(0, 9);
        case (k)
            0, 1, 2: ins[27:26] = 2'b00;
            3, 4:    ins[27:26] = 2'b01;
            5:       ins[27:25] = 3'b101;
            6, 7, 8: begin
                ins[27:25] = 3'b100;
                ins[24]    = ($urandom_range(0, 5) == 0);
                ins[23]    = ($urandom_range(0, 5) != 0);
                ins[15:0]  = 16'($urandom & $urandom & $urandom);
            end
            default: ins[27:26] = 2'b11;
        endcase
        return ins;
    endfunction

    initial begin
        out_t        t;
        out_t        adds_exp;
        logic [31:0] ins;
        logic        v, st, fl;

        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_bundle", dut_out(), '0);
        check("reset_ready", ReadyD, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        adds_exp = base(4'hE, 4'd2, 4'd1, 4'b0100); adds_exp.reg_w = 1'b1; adds_exp.flag_w = 2'b11;
        vecs.push_back('{"adds", 32'hE0921003, adds_exp});
        t = base(4'hE, 4'd2, 4'd1, 4'b0010); t.reg_w = 1'b1; t.flag_w = 2'b11;
        vecs.push_back('{"subs", 32'hE0521003, t});
        t = base(4'hE, 4'd2, 4'd1, 4'b0000); t.reg_w = 1'b1; t.flag_w = 2'b10;
        vecs.push_back('{"ands", 32'hE0121003, t});
        t = base(4'hE, 4'd5, 4'd4, 4'b0100); t.reg_w = 1'b1; t.alu_src = 1'b1;
        vecs.push_back('{"add_imm", 32'hE2854007, t});
        t = base(4'hE, 4'd1, 4'd15, 4'b0100); t.reg_w = 1'b1; t.pcs = 1'b1;
        vecs.push_back('{"add_pc", 32'hE081F002, t});
        t = base(4'hE, 4'd4, 4'd3, 4'b0100); t.alu_src = 1'b1; t.reg_w = 1'b1; t.mem_to_reg = 1'b1;
        vecs.push_back('{"ldr", 32'hE5943008, t});
        t = base(4'hE, 4'd4, 4'd3, 4'b0100); t.alu_src = 1'b1; t.mem_w = 1'b1; t.byte_en = 1'b1;
        vecs.push_back('{"strb", 32'hE5C43000, t});
        t = base(4'h0, 4'd0, 4'd0, 4'b0100); t.branch = 1'b1; t.alu_src = 1'b1; t.pcs = 1'b1;
        vecs.push_back('{"beq", 32'h0A000005, t});
        t = base(4'hE, 4'd0, 4'd0, 4'b0100); t.branch = 1'b1; t.alu_src = 1'b1; t.pcs = 1'b1; t.bl = 1'b1;
        vecs.push_back('{"bl", 32'hEB00000F, t});
        t = base(4'hE, 4'd0, 4'd0, 4'b0100); t.undef = 1'b1;
        vecs.push_back('{"ldmdb_undef", 32'hE9100002, t});
        t = base(4'hE, 4'd0, 4'd0, 4'b0100);
        vecs.push_back('{"ldm_empty_nop", 32'hE8900000, t});
        t = base(4'hE, 4'd0, 4'd0, 4'b0100); t.undef = 1'b1;
        vecs.push_back('{"op11_undef", 32'hEF000000, t});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].instr, 1'b1, 1'b0, 1'b0);
            tick();
            check(vecs[i].name, dut_out(), vecs[i].exp);
            check({vecs[i].name, "_ready"}, ReadyD, 1'b1);
        end

        drive(32'hE0921003, 1'b0, 1'b0, 1'b0);
        tick();
        check("invalid_bubble", dut_out(), '0);

        // LDMIA r0,{r1,r4,r7} with an ADDS waiting behind it
        drive(32'hE8900092, 1'b1, 1'b0, 1'b0);
        tick();
        check("ldm3_u0", dut_out(), uop_exp(4'hE, 4'd0, 4'd1, 6'd0, 1'b1));
        check("ldm3_ready0", ReadyD, 1'b0);
        drive(32'hE0921003, 1'b1, 1'b0, 1'b0);
        tick();
        check("ldm3_u1", dut_out(), uop_exp(4'hE, 4'd0, 4'd4, 6'd4, 1'b1));
        check("ldm3_ready1", ReadyD, 1'b0);
        tick();
        check("ldm3_u2", dut_out(), uop_exp(4'hE, 4'd0, 4'd7, 6'd8, 1'b1));
        check("ldm3_ready2", ReadyD, 1'b1);
        tick();
        check("ldm3_next_adds", dut_out(), adds_exp);

        // STMIA r2,{r3,r5} with a stall on the second cycle
        drive(32'hE8820028, 1'b1, 1'b0, 1'b0);
        tick();
        check("stm_u0", dut_out(), uop_exp(4'hE, 4'd2, 4'd3, 6'd0, 1'b0));
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check("stm_stall_hold", dut_out(), uop_exp(4'hE, 4'd2, 4'd3, 6'd0, 1'b0));
        check("stm_stall_ready", ReadyD, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("stm_u1", dut_out(), uop_exp(4'hE, 4'd2, 4'd5, 6'd4, 1'b0));
        check("stm_memwe", MemWE, 1'b1);
        check("stm_ready_end", ReadyD, 1'b1);

        // LDMIA r0,{r1-r3} flushed after the first micro-op
        drive(32'hE890000E, 1'b1, 1'b0, 1'b0);
        tick();
        check("flush_u0", dut_out(), uop_exp(4'hE, 4'd0, 4'd1, 6'd0, 1'b1));
        drive(32'hE0921003, 1'b1, 1'b1, 1'b1);
        tick();
        check("flush_bundle", dut_out(), '0);
        check("flush_ready", ReadyD, 1'b1);
        drive(32'hE0921003, 1'b1, 1'b0, 1'b0);
        tick();
        check("flush_next_adds", dut_out(), adds_exp);

        // LDMIA r0,{r1,r15}: the r15 load redirects the PC
        drive(32'hE8908002, 1'b1, 1'b0, 1'b0);
        tick();
        check("ldm_pc_u0", dut_out(), uop_exp(4'hE, 4'd0, 4'd1, 6'd0, 1'b1));
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ldm_pc_u1", dut_out(), uop_exp(4'hE, 4'd0, 4'd15, 6'd4, 1'b1));
        check("ldm_pc_pcse", PCSE, 1'b1);

        // LDMIA r0!,{r1,r2}
        drive(32'hE8B00006, 1'b1, 1'b0, 1'b0);
        tick();
        check("ldm_wb_u0", dut_out(), uop_exp(4'hE, 4'd0, 4'd1, 6'd0, 1'b1));
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ldm_wb_u1", dut_out(), uop_exp(4'hE, 4'd0, 4'd2, 6'd4, 1'b1));
`ifdef PIPE_DECODER_WB_UOP_EN
        check("ldm_wb_ready1", ReadyD, 1'b0);
        tick();
        t = base(4'hE, 4'd0, 4'd0, 4'b0100); t.alu_src = 1'b1; t.reg_w = 1'b1; t.off = 6'd8;
        check("ldm_wb_u2", dut_out(), t);
        check("ldm_wb_ready2", ReadyD, 1'b1);
`else
        check("ldm_wb_ready1", ReadyD, 1'b1);
        tick();
        check("ldm_wb_no_extra", dut_out(), '0);
`endif

        // Reset in the middle of a sequence
        drive(32'hE890000E, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midseq_reset_bundle", dut_out(), '0);
        check("midseq_reset_ready", ReadyD, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        q.delete();
        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            ins = rand_instr();
            v   = ($urandom_range(0, 99) < 85);
            st  = ($urandom_range(0, 99) < 15);
            fl  = ($urandom_range(0, 99) < 4);
            drive(ins, v, st, fl);
            if (fl) begin
                cur = '0;
                q.delete();
            end else if (!st) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                end else if (v) begin
                    model_expand(ins);
                    cur = q.pop_front();
                end else begin
                    cur = '0;
                end
            end
            tick();
            check($sformatf("rand_bundle@%0d", c), dut_out(), cur);
            check($sformatf("rand_ready@%0d", c), ReadyD, (q.size() == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
